// File: rtl/lut_cfg_pkg.sv
// lut_cfg_pkg: shared definitions for the K-input configurable look-up unit.
//   lut_state_e  configuration FSM states (UNCONF, LOAD, READY)
//   K_MIN/K_MAX  legal range of the LUT input count
//   cnt_width()  width of the configuration bit counter (must hold 2**K)
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        UNCONF = 2'd0,
        LOAD   = 2'd1,
        READY  = 2'd2
    } lut_state_e;

    localparam int unsigned K_MIN = 2;
    localparam int unsigned K_MAX = 6;

    function automatic int unsigned cnt_width(input int unsigned k);
        return k + 1;
    endfunction

endpackage

// File: rtl/lut_cfg_ctrl.sv
// lut_cfg_ctrl: configuration FSM and bit counter for lut_k_cfg.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   prgm_b        0 = configuration mode, 1 = user mode
//   cfg_en        serial shift enable
//   shift_en      table shifts on this edge
//   ready         FSM in READY
//   cfg_done      DEPTH (or more) bits shifted in the current load
//   cfg_err       sticky: user mode entered with an incomplete load
module lut_cfg_ctrl
    import lut_cfg_pkg::*;
#(
    parameter int unsigned K = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic prgm_b,
    input  logic cfg_en,
    output logic shift_en,
    output logic ready,
    output logic cfg_done,
    output logic cfg_err
);

    localparam int unsigned   CW   = cnt_width(K);
    localparam logic [CW-1:0] FULL = CW'(1 << K);

    lut_state_e    r_state;
    lut_state_e    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_err;
    logic          w_err_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= UNCONF;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        case (r_state)
            UNCONF, READY: begin
                if (!prgm_b) begin
                    // the entry edge itself may carry a counted shift
                    w_state_nxt = LOAD;
                    w_cnt_nxt   = cfg_en ? CW'(1) : '0;
                    w_err_nxt   = 1'b0;
                end
            end
            LOAD: begin
                if (prgm_b) begin
                    if (r_cnt == FULL) begin
                        w_state_nxt = READY;
                    end else begin
                        w_state_nxt = UNCONF;
                        w_err_nxt   = 1'b1;
                    end
                end else if (cfg_en && (r_cnt != FULL)) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = UNCONF;
        endcase
    end

    assign shift_en = ~prgm_b & cfg_en;
    assign ready    = (r_state == READY);
    assign cfg_done = ((r_state == LOAD) || (r_state == READY)) && (r_cnt == FULL);
    assign cfg_err  = r_err;

endmodule

// File: rtl/lut_k_cfg.sv
// lut_k_cfg: K-input look-up unit with serial, daisy-chainable configuration.
// In user mode it acts as a combinational LUT or a 2**K x 1 distributed RAM.
// Optional SRL mode is compiled in with `define LUT_SRL_EN.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   prgm_b            0 = configuration mode, 1 = user mode
//   cfg_en, cfg_din   serial configuration shift enable and data in
//   cfg_dout          serial data out to next element (mem[0])
//   cfg_done, cfg_err load complete / sticky incomplete-load flag
//   ready             unit configured and in user mode
//   addr              LUT select / RAM address
//   we, gwe, wdata    RAM write enable, global write qualifier, write data
//   srl_en            SRL shift enable (LUT_SRL_EN builds only)
//   lut_out           mem[addr] when ready, else 0
//   srl_q             mem[DEPTH-1] when ready in SRL builds, else 0
module lut_k_cfg
    import lut_cfg_pkg::*;
#(
    parameter int unsigned       K    = 4,
    parameter logic [(1<<K)-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         prgm_b,
    input  logic         cfg_en,
    input  logic         cfg_din,
    output logic         cfg_dout,
    output logic         cfg_done,
    output logic         cfg_err,
    output logic         ready,
    input  logic [K-1:0] addr,
    input  logic         we,
    input  logic         gwe,
    input  logic         wdata,
    input  logic         srl_en,
    output logic         lut_out,
    output logic         srl_q
);

    localparam int unsigned DEPTH = 1 << K;

    generate
        if ((K < K_MIN) || (K > K_MAX)) begin : g_bad_k
            $error("lut_k_cfg: K outside supported range");
        end
    endgenerate

    logic [DEPTH-1:0] r_mem;
    logic             w_shift;
    logic             w_ready;

    lut_cfg_ctrl #(
        .K(K)
    ) u_ctrl (
        .clk      (clk),
        .reset_n  (reset_n),
        .prgm_b   (prgm_b),
        .cfg_en   (cfg_en),
        .shift_en (w_shift),
        .ready    (w_ready),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    // Configuration shifting takes priority; user writes only happen in READY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem <= INIT;
        end else if (w_shift) begin
            r_mem <= {cfg_din, r_mem[DEPTH-1:1]};
        end else if (w_ready) begin
`ifdef LUT_SRL_EN
            if (srl_en && gwe) begin
                r_mem <= {r_mem[DEPTH-2:0], wdata};
            end else
`endif
            if (we && gwe) begin
                r_mem[addr] <= wdata;
            end
        end
    end

    assign cfg_dout = r_mem[0];
    assign ready    = w_ready;
    assign lut_out  = w_ready & r_mem[addr];

`ifdef LUT_SRL_EN
    assign srl_q = w_ready & r_mem[DEPTH-1];
`else
    logic w_unused_srl_en;
    assign w_unused_srl_en = srl_en;
    assign srl_q           = 1'b0;
`endif

endmodule
